selector_ctrl: RTL and testbench

SELECTOR_CTRL -- requirements
Module: selector_ctrl

---
 rtl/selector_pkg.sv | 24 ++
 rtl/selector_pos.sv | 81 ++++++++
 rtl/selector_ctrl.sv | 168 ++++++++++++++++
 tb/tb_selector_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/selector_pkg.sv
// selector_pkg: shared constants and types for the selector sprite block.
// Holds the sprite box size, the move_dir encoding and the fetch FSM states.
package selector_pkg;

  // Sprite bitmap geometry: 59 pixels wide, 66 rows high.
  localparam int SEL_W = 59;
  localparam int SEL_H = 66;

  // Move command encoding carried on move_dir.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } move_dir_e;

  // ROM access sequencer: FETCH drives rom_addr, LATCH sees rom_data.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/selector_pos.sv
// selector_pos: sprite position registers. Move commands are held as a single
// pending move (last one wins) and applied at frame_start, saturating so the
// whole 59x66 box stays on screen.
module selector_pos
  import selector_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int STEP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       move_valid,
  input  logic [1:0] move_dir,
  output logic [9:0] sel_x,
  output logic [9:0] sel_y
);

  localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - SEL_W);
  localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - SEL_H);
  localparam logic [9:0]  X_HOME = 10'((SCREEN_W - SEL_W) / 2);
  localparam logic [9:0]  Y_HOME = 10'((SCREEN_H - SEL_H) / 2);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [9:0]  r_sel_x;
  logic [9:0]  r_sel_y;
  logic        r_pend_valid;
  move_dir_e   r_pend_dir;

  // Position plus STEP, one bit wider so the clamp sees any overflow.
  logic [10:0] w_x_up;
  logic [10:0] w_y_up;
  logic [9:0]  w_next_x;
  logic [9:0]  w_next_y;

  assign w_x_up = {1'b0, r_sel_x} + STEP_W;
  assign w_y_up = {1'b0, r_sel_y} + STEP_W;

  // Position after applying the pending move, clamped to the screen.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
    w_next_x = r_sel_x;
    w_next_y = r_sel_y;
    if (r_pend_valid) begin
      case (r_pend_dir)
        DIR_UP:    w_next_y = ({1'b0, r_sel_y} < STEP_W) ? '0 : 10'({1'b0, r_sel_y} - STEP_W);
        DIR_DOWN:  w_next_y = (w_y_up > {1'b0, Y_MAX}) ? Y_MAX : w_y_up[9:0];
        DIR_LEFT:  w_next_x = ({1'b0, r_sel_x} < STEP_W) ? '0 : 10'({1'b0, r_sel_x} - STEP_W);
        DIR_RIGHT: w_next_x = (w_x_up > {1'b0, X_MAX}) ? X_MAX : w_x_up[9:0];
        default:   ;
      endcase
    end
  end

  // Apply the pending move at frame start; a move arriving in the same cycle becomes the next pending one.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      r_sel_x      <= X_HOME;
      r_sel_y      <= Y_HOME;
      r_pend_valid <= 1'b0;
      r_pend_dir   <= DIR_UP;
    end else begin
      if (frame_start) begin
        r_sel_x <= w_next_x;
        r_sel_y <= w_next_y;
      end
      if (move_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_dir   <= move_dir_e'(move_dir);
      end else if (frame_start) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign sel_x = r_sel_x;
  assign sel_y = r_sel_y;

endmodule

// File: rtl/selector_ctrl.sv
// selector_ctrl: draws a 59x66 selector sprite from an external bitmap ROM.
// Each line inside the box fetches one ROM row into row_buf; hit tests share
// the ROM port, with line fetches taking priority. Position lives in
// selector_pos.
// Optional build macro: SELECTOR_BLINK_EN gates pixel_on with a frame counter.
module selector_ctrl
  import selector_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int STEP     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [9:0]       vcount,
  input  logic [9:0]       hcount,
  input  logic             move_valid,
  input  logic [1:0]       move_dir,
  input  logic             hit_req,
  input  logic [9:0]       hit_x,
  input  logic [9:0]       hit_y,
  output logic [6:0]       rom_addr,
  input  logic [SEL_W-1:0] rom_data,
  output logic             pixel_on,
  output logic             hit_ack,
  output logic             hit_result,
  output logic [9:0]       sel_x,
  output logic [9:0]       sel_y
);

  localparam logic [9:0] COL_LAST = 10'(SEL_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(SEL_H - 1);
  localparam logic [5:0] BIT_LEFT = 6'(SEL_W - 1);

  state_e           r_state;
  logic [6:0]       r_rom_addr;
  logic [SEL_W-1:0] r_row_buf;
  logic             r_is_hit;       // current ROM access belongs to a hit test
  logic             r_miss_ack;     // one-cycle ack for a hit outside the box
  logic             r_line_pend;    // line_start seen while the ROM port was busy
  logic [9:0]       r_pend_vcount;
  logic [5:0]       r_hit_bit;      // rom_data bit selected by hit_x
  logic             r_pixel_on;

  logic       w_line_go;
  logic [9:0] w_line_v;
  logic [9:0] w_line_off;
  logic       w_line_in;
  logic [9:0] w_hit_xoff;
  logic [9:0] w_hit_yoff;
  logic       w_hit_in;
  logic       w_hit_go;
  logic       w_hit_latch;
  logic [9:0] w_hoff;
  logic       w_h_in;
  logic [5:0] w_pix_bit;
  logic       w_visible;

  selector_pos #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .STEP     (STEP)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .move_valid  (move_valid),
    .move_dir    (move_dir),
    .sel_x       (sel_x),
    .sel_y       (sel_y)
  );

  // A live line_start wins over a deferred one; both carry their own line number.
  assign w_line_go  = line_start | r_line_pend;
  assign w_line_v   = line_start ? vcount : r_pend_vcount;
  assign w_line_off = w_line_v - sel_y;
  assign w_line_in  = (w_line_v >= sel_y) && (w_line_off <= ROW_LAST);

  assign w_hit_xoff = hit_x - sel_x;
  assign w_hit_yoff = hit_y - sel_y;
  assign w_hit_in   = (hit_x >= sel_x) && (w_hit_xoff <= COL_LAST) &&
                      (hit_y >= sel_y) && (w_hit_yoff <= ROW_LAST);
  // The miss-ack cycle still sees hit_req high; do not restart on it.
  assign w_hit_go   = hit_req && !r_miss_ack && !w_line_go;

  assign w_hit_latch = (r_state == ST_LATCH) && r_is_hit;

  assign w_hoff    = hcount - sel_x;
  assign w_h_in    = (hcount >= sel_x) && (w_hoff <= COL_LAST);
  assign w_pix_bit = w_h_in ? (BIT_LEFT - w_hoff[5:0]) : '0;

`ifdef SELECTOR_BLINK_EN
  logic [5:0] r_frame_cnt;

  // Free-running frame counter; sprite shows for 32 frames, hides for 32.
  always_ff @(posedge clk) begin
    if (rst) r_frame_cnt <= '0;
    else if (frame_start) r_frame_cnt <= r_frame_cnt + 6'd1;
  end

  assign w_visible = ~r_frame_cnt[5];
`else
  assign w_visible = 1'b1;
`endif

  // ROM port sequencer: line fetches first, then hit tests, one access at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rom_addr    <= '0;
      r_row_buf     <= '0;
      r_is_hit      <= 1'b0;
      r_miss_ack    <= 1'b0;
      r_line_pend   <= 1'b0;
      r_pend_vcount <= '0;
      r_hit_bit     <= '0;
    end else begin
      r_miss_ack <= 1'b0;
      if (line_start && (r_state != ST_IDLE)) begin
        r_line_pend   <= 1'b1;
        r_pend_vcount <= vcount;
      end
      case (r_state)
        ST_FETCH: r_state <= ST_LATCH;
        default: begin
          // IDLE and LATCH may both start the next access without a dead cycle.
          if ((r_state == ST_LATCH) && !r_is_hit) r_row_buf <= rom_data;
          if (w_line_go) begin
            r_line_pend <= 1'b0;
            r_is_hit    <= 1'b0;
            if (w_line_in) begin
              r_state    <= ST_FETCH;
              r_rom_addr <= w_line_off[6:0];
            end else begin
              r_state   <= ST_IDLE;
              r_row_buf <= '0;
            end
          end else if ((r_state == ST_IDLE) && w_hit_go) begin
            if (w_hit_in) begin
              r_state    <= ST_FETCH;
              r_is_hit   <= 1'b1;
              r_rom_addr <= w_hit_yoff[6:0];
              r_hit_bit  <= BIT_LEFT - w_hit_xoff[5:0];
            end else begin
              r_miss_ack <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Registered pixel: row_buf bit under hcount, blanked outside the box.
  always_ff @(posedge clk) begin
    if (rst) r_pixel_on <= 1'b0;
    else     r_pixel_on <= w_h_in & r_row_buf[w_pix_bit] & w_visible;
  end

  assign rom_addr   = r_rom_addr;
  assign pixel_on   = r_pixel_on;
  assign hit_ack    = w_hit_latch | r_miss_ack;
  assign hit_result = w_hit_latch ? rom_data[r_hit_bit] : 1'b0;

endmodule

// File: tb/tb_selector_ctrl.sv
// tb_selector_ctrl: directed bench for selector_ctrl with a registered bitmap
// ROM model. Expected values are hand-derived from the ROM contents below.
module tb_selector_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        line_start;
  logic [9:0]  vcount;
  logic [9:0]  hcount;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        hit_req;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;
  logic [6:0]  rom_addr;
  logic [58:0] rom_data;
  logic        pixel_on;
  logic        hit_ack;
  logic        hit_result;
  logic [9:0]  sel_x;
  logic [9:0]  sel_y;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  selector_ctrl #(
    .SCREEN_W (640),
    .SCREEN_H (480),
    .STEP     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .vcount      (vcount),
    .hcount      (hcount),
    .move_valid  (move_valid),
    .move_dir    (move_dir),
    .hit_req     (hit_req),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_on    (pixel_on),
    .hit_ack     (hit_ack),
    .hit_result  (hit_result),
    .sel_x       (sel_x),
    .sel_y       (sel_y)
  );

  // Bitmap: row 0 lights cols 26..32 (bits 32..26); row r otherwise lights
  // bit r%59; row 23 also lights col 0 (bit 58).
  function automatic logic [58:0] rom_row(input logic [6:0] a);
    logic [58:0] v;
    v = '0;
    if (a == 7'd0) begin
      v[32:26] = '1;
    end else begin
      v[int'(a) % 59] = 1'b1;
      if (a == 7'd23) v[58] = 1'b1;
    end
    return v;
  endfunction

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_data <= rom_row(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic [9:0] v);
    line_start = 1'b1;
    vcount     = v;
    tick();
    line_start = 1'b0;
  endtask

  // Sweep hcount across the visible line; pixel_on must be 1 exactly in lo..hi.
  task automatic scan(input string tag, input int lo, input int hi);
    for (int h = 0; h < 640; h++) begin
      hcount = 10'(h);
      tick();
      check($sformatf("%s@%0d", tag, h), pixel_on, (h >= lo) && (h <= hi));
    end
    hcount = '0;
  endtask

  // Issue one hit test; exp_lat 2 = ROM access, 1 = outside box, 0 = no ack within the window.
  task automatic hit_test(input string tag, input logic [9:0] x, input logic [9:0] y,
                          input logic exp_res, input int exp_lat, input logic [6:0] exp_addr);
    int   lat;
    logic res;
    hit_x   = x;
    hit_y   = y;
    hit_req = 1'b1;
    lat     = 0;
    res     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (hit_ack) begin
        lat = i;
        res = hit_result;
        break;
      end
    end
    hit_req = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, res, exp_res);
    if (exp_lat == 2) check({tag, "_addr"}, rom_addr, exp_addr);
    tick();
    check({tag, "_ackdrop"}, hit_ack, 0);
    tick();
  endtask

  task automatic move_frame(input logic [1:0] dir);
    move_valid = 1'b1;
    move_dir   = dir;
    tick();
    move_valid  = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_x;
    int exp_y;
    logic seen;

    rst = 1'b1; frame_start = 0; line_start = 0; vcount = 0; hcount = 0;
    move_valid = 0; move_dir = 0; hit_req = 0; hit_x = 0; hit_y = 0;
    repeat (3) tick();

    // Reset state
    check("rst_rom_addr", rom_addr, 0);
    check("rst_pixel_on", pixel_on, 0);
    check("rst_hit_ack", hit_ack, 0);
    check("rst_hit_result", hit_result, 0);
    check("rst_sel_x", sel_x, 290);
    check("rst_sel_y", sel_y, 207);
    rst = 1'b0;
    tick();

    // First box row: rom_addr 0, row 0 lights hcount 316..322
    line(10'd207);
    check("line207_addr", rom_addr, 0);
    repeat (2) tick();
    scan("row0_pix", 316, 322);

    // Line above the box: no fetch, row_buf cleared
    line(10'd100);
    tick();
    check("line100_addr", rom_addr, 0);
    scan("line100_pix", 1, 0);

    // Hit tests: inside (row 23), inside but clear, far outside, corners
    hit_test("hit_290_230", 10'd290, 10'd230, 1'b1, 2, 7'd23);
    hit_test("hit_300_230", 10'd300, 10'd230, 1'b0, 2, 7'd23);
    hit_test("hit_0_0",     10'd0,   10'd0,   1'b0, 1, 7'd0);
    hit_test("hit_348_272", 10'd348, 10'd272, 1'b0, 2, 7'd65);
    hit_test("hit_349_230", 10'd349, 10'd230, 1'b0, 1, 7'd0);

    // line_start during a hit FETCH: hit acks, then line fetch follows at once
    hit_x = 10'd290; hit_y = 10'd230; hit_req = 1'b1;
    tick();
    check("pri_hit_addr", rom_addr, 23);
    check("pri_hit_noack", hit_ack, 0);
    line_start = 1'b1; vcount = 10'd210;
    tick();
    line_start = 1'b0;
    check("pri_hit_ack", hit_ack, 1);
    check("pri_hit_res", hit_result, 1);
    hit_req = 1'b0;
    tick();
    check("pri_line_ackdrop", hit_ack, 0);
    check("pri_line_addr", rom_addr, 3);
    repeat (2) tick();
    hcount = 10'd345; tick(); check("pri_row3_pix345", pixel_on, 1);
    hcount = 10'd344; tick(); check("pri_row3_pix344", pixel_on, 0);
    hcount = 10'd346; tick(); check("pri_row3_pix346", pixel_on, 0);
    hcount = 10'd0;

    // Reset during a hit fetch aborts it with no ack
    hit_x = 10'd290; hit_y = 10'd230; hit_req = 1'b1;
    tick();
    check("abort_accepted", rom_addr, 23);
    rst = 1'b1; hit_req = 1'b0;
    tick();
    check("abort_rst_addr", rom_addr, 0);
    rst = 1'b0;
    seen = hit_ack;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | hit_ack;
    end
    check("abort_no_ack", seen, 0);
    check("abort_sel_x", sel_x, 290);

    // 200 left moves, one per frame, saturating at 0
    exp_x = 290;
    for (int i = 0; i < 200; i++) begin
      move_frame(2'd2);
      exp_x = (exp_x >= 4) ? exp_x - 4 : 0;
      check($sformatf("left_%0d", i), sel_x, exp_x);
    end
    // Right moves up to the 581 clamp
    for (int i = 0; i < 150; i++) begin
      move_frame(2'd3);
      exp_x = (exp_x + 4 > 581) ? 581 : exp_x + 4;
      check($sformatf("right_%0d", i), sel_x, exp_x);
    end
    // Up to 0, then down to the 414 clamp
    exp_y = 207;
    for (int i = 0; i < 60; i++) begin
      move_frame(2'd0);
      exp_y = (exp_y >= 4) ? exp_y - 4 : 0;
      check($sformatf("up_%0d", i), sel_y, exp_y);
    end
    for (int i = 0; i < 110; i++) begin
      move_frame(2'd1);
      exp_y = (exp_y + 4 > 414) ? 414 : exp_y + 4;
      check($sformatf("down_%0d", i), sel_y, exp_y);
    end

    // move_valid with frame_start: old move (left) applied, new one (up) pending
    move_valid = 1'b1; move_dir = 2'd2;
    tick();
    move_dir = 2'd0; frame_start = 1'b1;
    tick();
    move_valid = 1'b0; frame_start = 1'b0;
    check("same_cyc_x", sel_x, 577);
    check("same_cyc_y", sel_y, 414);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("same_cyc_next_y", sel_y, 410);
    check("same_cyc_next_x", sel_x, 577);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("no_pend_y", sel_y, 410);
    // Last move of the frame wins
    move_valid = 1'b1; move_dir = 2'd3; tick();
    move_dir = 2'd1; tick();
    move_valid = 1'b0; frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("last_wins_x", sel_x, 577);
    check("last_wins_y", sel_y, 414);

`ifdef SELECTOR_BLINK_EN
    // Blink: visible in frames 0..31, dark in 32..63
    do_reset();
    line(10'd207);
    repeat (3) tick();
    for (int f = 0; f < 64; f++) begin
      hcount = 10'd316;
      tick();
      check($sformatf("blink_f%0d", f), pixel_on, f < 32);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    hcount = '0;
`else
    do_reset();
    check("final_rst_sel_y", sel_y, 207);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
